// File: rtl/issue_arb.sv
// Issue arbiter: round-robin grant across reservation stations into a 2-entry
// in-order queue feeding register-read, with flush and tag-selective recovery.

package ooop_types;
    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] rob_tag;
        logic [15:0]      payload;
    } rs_entry_t;
endpackage

module issue_arb
    import ooop_types::*;
#(
    parameter  int N_SRC   = 3,
    parameter  int Q_DEPTH = 2,
    localparam int SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 recover_i,
    input  logic [ROB_DEPTH-1:0] live_tag_i,
    input  logic [N_SRC-1:0]     src_valid_i,
    input  rs_entry_t            src_entry_i [N_SRC],
    output logic [N_SRC-1:0]     src_ready_o,
    output logic                 out_valid_o,
    output rs_entry_t            out_entry_o,
    output logic [SRC_W-1:0]     out_src_o,
    input  logic                 out_ready_i
);

    rs_entry_t        slot_entry [Q_DEPTH];
    logic [SRC_W-1:0] slot_src   [Q_DEPTH];
    logic             head;
    logic [1:0]       count;
    logic [SRC_W-1:0] rr_ptr;

    logic             tail;
    logic             space;
    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic             push;
    logic             pop;
    logic             h_live;
    logic             t_live;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        return (v == SRC_W'(N_SRC - 1)) ? '0 : v + 1'b1;
    endfunction

    // With two slots the tail index is head advanced by count, modulo 2.
    assign tail  = head ^ count[0];

    assign out_valid_o = (count != 2'd0) && !recover_i && !flush_i;
    assign out_entry_o = out_valid_o ? slot_entry[head] : '0;
    assign out_src_o   = out_valid_o ? slot_src[head]   : '0;

    assign pop   = out_valid_o && out_ready_i;
    assign space = (count < 2'(Q_DEPTH)) || ((count == 2'(Q_DEPTH)) && pop);

    always_comb begin
        logic [SRC_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = rr_ptr;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!win_found && src_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    always_comb begin
        src_ready_o = '0;
        if (rst_n && win_found && space && !flush_i && !recover_i)
            src_ready_o[win_idx] = 1'b1;
    end

    assign push = |src_ready_o;

    assign h_live = (count != 2'd0) && live_tag_i[slot_entry[head].rob_tag];
    assign t_live = (count == 2'd2) && live_tag_i[slot_entry[~head].rob_tag];

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                slot_entry[i] <= '0;
                slot_src[i]   <= '0;
            end
            head   <= 1'b0;
            count  <= 2'd0;
            rr_ptr <= '0;
        end else if (recover_i) begin
            // Dead slots are zeroed; a lone live tail becomes the head so order holds.
            if (!h_live) begin
                slot_entry[head] <= '0;
                slot_src[head]   <= '0;
            end
            if (!t_live) begin
                slot_entry[~head] <= '0;
                slot_src[~head]   <= '0;
            end
            if (!h_live && t_live)
                head <= ~head;
            count <= {1'b0, h_live} + {1'b0, t_live};
        end else begin
            if (pop) begin
                slot_entry[head] <= '0;
                slot_src[head]   <= '0;
                head             <= ~head;
            end
            // When full and popping, tail aliases head; this later write wins.
            if (push) begin
                slot_entry[tail] <= src_entry_i[win_idx];
                slot_src[tail]   <= win_idx;
                rr_ptr           <= wrap_inc(win_idx);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge clk) $onehot0(src_ready_o));

endmodule

// File: doc/issue_arb.md
Name: issue_arb

Overview:
Consumer end of the reservation-station issue handshake. The block collects `issue_valid`/`issue_entry` from N_SRC reservation stations and grants exactly one per cycle, round-robin, through that RS's `issue_ready`. It buffers granted entries in a 2-entry in-order queue ahead of the register-read/execute stage. The queue squashes on flush, and on recovery it removes only entries whose ROB tag is no longer live.

Parameters:
- N_SRC, 3, number of reservation stations arbitrated (ALU, LSU, BRU order, index 0..N_SRC-1).
- Q_DEPTH, 2, output queue depth; fixed at 2 in this revision.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  full pipeline flush.
- recover_i  in  1  branch recovery; squash entries whose tag is not live.
- live_tag_i  in  ooop_types::ROB_DEPTH  ROB live-tag bitmap, valid with recover_i.
- src_valid_i  in  N_SRC  per-RS issue_valid.
- src_entry_i  in  N_SRC x rs_entry_t  per-RS issue_entry; held stable by the RS while valid and not granted.
- src_ready_o  out  N_SRC  per-RS issue_ready (grant); at most one bit set.
- out_valid_o  out  1  queue head valid.
- out_entry_o  out  rs_entry_t  queue head entry; '0 when out_valid_o=0.
- out_src_o  out  $clog2(N_SRC) (min 1)  source RS index of the head.
- out_ready_i  in  1  downstream accepts the head.

Behaviour:
- Reset (rst_n=0 at posedge):
  - queue empty, count=0, rr_ptr=0.
  - out_valid_o=0, out_entry_o='0, out_src_o=0.
  - src_ready_o=0 while in reset.
- State:
  - 2 slots {entry, src}, head index, count 0..2.
  - rr_ptr 0..N_SRC-1.
- Arbitration (combinational, normal cycles):
  - Winner is the first i with src_valid_i[i], scanning rr_ptr, rr_ptr+1, ... mod N_SRC.
  - space = (count<2) || (count==2 && out_valid_o && out_ready_i); i.e. push-while-full is allowed when a pop happens in the same cycle.
  - src_ready_o[winner] = space && !flush_i && !recover_i. All other bits are 0.
  - Every src_ready_o bit is 0 when no src_valid_i bit is set.
- Grant fire (src_valid_i[w] && src_ready_o[w]):
  - push {src_entry_i[w], w} at the tail, one cycle latency.
  - rr_ptr <= (w+1) mod N_SRC.
  - Without a fire, rr_ptr holds.
- Pop: out_valid_o && out_ready_i advances the head.
  - Push and pop in the same cycle leave count unchanged.
  - A pushed entry is visible at out_valid_o the next cycle; there is no same-cycle bypass.
- Output: out_valid_o = (count!=0) && !recover_i && !flush_i.
  - This blocks a pop during flush or recover cycles.
  - out_entry_o/out_src_o come from the head slot and are stable until popped.
- Ordering: FIFO; the head is the oldest grant.
- flush_i (priority below reset):
  - queue cleared, count=0, rr_ptr=0.
  - no grant, no pop.
- recover_i (priority below flush):
  - Each occupied slot with !live_tag_i[entry.rob_tag] is cleared.
  - Survivors compact: if the head is dead and the tail is live, the tail becomes the head, keeping order.
  - count = number of survivors.
  - no grant, no pop, rr_ptr holds.
- Cleared slots are written to '0.
- Downstream stall (out_ready_i=0): the queue fills to 2. src_ready_o then stays 0 until a pop cycle, so a waiting RS keeps holding its selection.
- Invariant: sum of src_ready_o ≤ 1. An assertion is required.

Test Plan:
1. Reset then idle: after reset, all src_valid_i=0 for 5 cycles -> out_valid_o=0, src_ready_o=000, rr_ptr=0.
2. Round-robin fairness with all 3 sources valid continuously and out_ready_i=1:
   - grants go 0,1,2,0,1,2 on consecutive cycles;
   - out_src_o shows the same sequence delayed one cycle.
3. Backpressure:
   - Setup: out_ready_i=0, src 1 valid with rob_tag=5, src 2 valid with rob_tag=6.
   - Required: the first two grants fill the queue; src_ready_o then stays 000 while both stay valid.
   - Release: raising out_ready_i pops tag 5, with a same-cycle grant accepted (count stays 2).
4. Recovery squash:
   - Setup: queue holds head tag 3 and tail tag 7; pulse recover_i with live_tag bit3=0, bit7=1.
   - Required next cycle: count=1, head tag 7.
   - Required during the recover cycle: src_ready_o=000, out_valid_o=0.
5. Flush mid-stall:
   - Setup: queue full, src 0 valid; assert flush_i.
   - Required next cycle: out_valid_o=0, count=0, rr_ptr=0, no grant in the flush cycle.
6. Synchronous reset asserted while the queue is full and grants are in flight -> next cycle all outputs are at their reset values and no entry leaks out.
